// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async byte-wide SRAM port between requesters A and B.
// Each access runs IDLE -> SETUP -> ACCESS -> DONE with registered strobes.
module sram_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int ACCESS_CYCLES = 2,
  parameter bit PRIORITY_A    = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  output logic [7:0]        a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_load,
  output logic              mem_store,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  if (ACCESS_CYCLES < 1) begin : g_bad_cycles
    $error("sram_arbiter: ACCESS_CYCLES must be >= 1");
  end

  localparam int CW =
    (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rr_last_b;
  logic          gnt_b;
  logic          we_q;
  logic          pick_b;

  // Winner selection: sole requester wins, ties by priority or round-robin
  always_comb begin
    pick_b = 1'b0;
    unique case ({a_req, b_req})
      2'b01:   pick_b = 1'b1;
      2'b11:   pick_b = PRIORITY_A ? 1'b0 : ~rr_last_b;
      default: pick_b = 1'b0;
    endcase
  end

  // Access sequencer with registered strobes, acks and read data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_last_b <= 1'b1;
      gnt_b     <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_load  <= 1'b0;
      mem_store <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (a_req || b_req) begin
            state     <= SETUP;
            busy      <= 1'b1;
            gnt_b     <= pick_b;
            rr_last_b <= pick_b;
            we_q      <= pick_b ? b_we : a_we;
            mem_addr  <= pick_b ? b_addr : a_addr;
            mem_wdata <= pick_b ? b_wdata : a_wdata;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          cnt       <= CNT_LOAD;
          mem_load  <= ~we_q;
          mem_store <= we_q;
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= DONE;
            mem_load  <= 1'b0;
            mem_store <= 1'b0;
            a_ack     <= ~gnt_b;
            b_ack     <= gnt_b;
            if (!we_q) begin
              if (gnt_b) b_rdata <= mem_rdata;
              else       a_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter.
// Drivers queue expectations; a monitor checks each ack.
module tb_sram_arbiter;
  localparam int AW = 19;
  localparam int AC = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0;
  logic b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic mem_load, mem_store, busy;
  logic a_ack2, b_ack2;
  logic [7:0] a_rdata2, b_rdata2;
  logic [AW-1:0] mem_addr2;
  logic [7:0] mem_wdata2;
  logic mem_load2, mem_store2, busy2;

  sram_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(AC),
                 .PRIORITY_A(1'b0)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_load(mem_load), .mem_store(mem_store),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  sram_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(AC),
                 .PRIORITY_A(1'b1)) dut_pa (
    .clock(clock), .reset(reset2),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ack(a_ack2), .a_rdata(a_rdata2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_ack(b_ack2), .b_rdata(b_rdata2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_load(mem_load2), .mem_store(mem_store2),
    .mem_rdata(mem_rdata), .busy(busy2)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] def_byte(input logic [AW-1:0] ad);
    return ad[7:0] ^ ad[15:8] ^ 8'h5A;
  endfunction

  // SRAM environment
  logic [7:0] sram [logic [AW-1:0]];
  always @(negedge clock) begin
    if (mem_store) sram[mem_addr] = mem_wdata;
    mem_rdata = sram.exists(mem_addr) ? sram[mem_addr]
                                      : def_byte(mem_addr);
  end

  // Reference model: memory contents as seen in issue order per port
  logic [7:0] ref_mem [logic [AW-1:0]];
  function automatic logic [7:0] ref_rd(input logic [AW-1:0] ad);
    return ref_mem.exists(ad) ? ref_mem[ad] : def_byte(ad);
  endfunction

  typedef struct {
    logic       we;
    logic [7:0] data;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  bit   ord[$];

  logic [7:0] last_a = '0, last_b = '0;
  logic a_ack_p = 1'b0, b_ack_p = 1'b0, busy_p = 1'b0;
  logic [AW-1:0] addr_p = '0;
  int store_cnt = 0, load_cnt = 0;
  int overlap = 0, unstable = 0;
  int n_ack_a = 0, n_ack_b = 0;
  int n_ack_a2 = 0, n_ack_b2 = 0;

  // Monitor
  always @(negedge clock) begin
    if (reset) begin
      last_a = '0;
      last_b = '0;
    end
    if (a_ack) begin
      n_ack_a++;
      ord.push_back(1'b0);
      chk("a_ack_pulse", a_ack_p, 0);
      chk("a_ack_expected", qa.size() > 0, 1);
      if (qa.size() > 0) begin : pop_a
        exp_t e;
        e = qa.pop_front();
        if (!e.we) last_a = e.data;
        chk("a_rdata", a_rdata, last_a);
        chk("b_rdata_hold", b_rdata, last_b);
      end
    end
    if (b_ack) begin
      n_ack_b++;
      ord.push_back(1'b1);
      chk("b_ack_pulse", b_ack_p, 0);
      chk("b_ack_expected", qb.size() > 0, 1);
      if (qb.size() > 0) begin : pop_b
        exp_t e;
        e = qb.pop_front();
        if (!e.we) last_b = e.data;
        chk("b_rdata", b_rdata, last_b);
        chk("a_rdata_hold", a_rdata, last_a);
      end
    end
    a_ack_p = a_ack;
    b_ack_p = b_ack;
    if (mem_load) load_cnt++;
    if (mem_store) store_cnt++;
    if (mem_load && mem_store) overlap++;
    if (!reset && !(busy && !busy_p) && mem_addr !== addr_p)
      unstable++;
    busy_p = busy;
    addr_p = mem_addr;
    if (a_ack2) n_ack_a2++;
    if (b_ack2) n_ack_b2++;
  end

  task automatic do_req(input bit pb, input bit we,
                        input logic [AW-1:0] ad,
                        input logic [7:0] wd,
                        output int lat, output int idle);
    exp_t e;
    bit got;
    e.we = we;
    if (we) begin
      ref_mem[ad] = wd;
      e.data = wd;
    end else begin
      e.data = ref_rd(ad);
    end
    if (pb) begin
      qb.push_back(e);
      b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
    end else begin
      qa.push_back(e);
      a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
    end
    got = 1'b0;
    lat = 0;
    idle = 0;
    while (!got && lat < 60) begin
      @(negedge clock);
      lat++;
      if (!busy) idle++;
      got = pb ? b_ack : a_ack;
    end
    chk(pb ? "b_req_done" : "a_req_done", got, 1);
    if (pb) b_req = 1'b0;
    else    a_req = 1'b0;
  endtask

  task automatic rand_port(input bit pb, input int n,
                           input bit gaps);
    logic [AW-1:0] ad;
    int lat, idle;
    for (int i = 0; i < n; i++) begin
      ad = '0;
      ad[AW-1] = pb;
      ad[2:0] = 3'($urandom_range(0, 7));
      do_req(pb, 1'($urandom_range(0, 1)), ad,
             8'($urandom), lat, idle);
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, idle, s0, l0, k, exp_a2;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // A write, latency and strobe shape
    s0 = store_cnt;
    l0 = load_cnt;
    do_req(1'b0, 1'b1, 19'h00123, 8'hA5, lat, idle);
    chk("t2_latency", lat, AC + 2);
    chk("t2_store_clocks", store_cnt - s0, AC);
    chk("t2_load_clocks", load_cnt - l0, 0);
    chk("t2_mem_addr", mem_addr, 19'h00123);
    chk("t2_mem_wdata", mem_wdata, 8'hA5);

    // B read at top address
    sram[19'h7FFFF] = 8'h3C;
    ref_mem[19'h7FFFF] = 8'h3C;
    @(negedge clock);
    do_req(1'b1, 1'b0, 19'h7FFFF, 8'h00, lat, idle);
    chk("t3_b_rdata", b_rdata, 8'h3C);
    chk("t3_a_rdata", a_rdata, 8'h00);

    // Reset in idle
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t1_b_rdata", b_rdata, 0);
    chk("t1_outs", {a_ack, b_ack, mem_load, mem_store, busy}, 0);
    chk("t1_mem_addr", mem_addr, 0);
    chk("t1_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    s0 = n_ack_a + n_ack_b;
    repeat (5) @(negedge clock);
    chk("t1_no_ack", n_ack_a + n_ack_b, s0);

    // A held through three reads
    do_req(1'b0, 1'b0, 19'h00001, 8'h00, lat, idle);
    chk("t6_first_lat", lat, AC + 2);
    for (int i = 0; i < 2; i++) begin
      do_req(1'b0, 1'b0, 19'(i + 2), 8'h00, lat, idle);
      chk("t6_spacing", lat, AC + 3);
      chk("t6_idle_gap", idle, 1);
    end

    // Random concurrent traffic
    fork
      rand_port(1'b0, 20, 1'b1);
      rand_port(1'b1, 20, 1'b1);
    join
    @(negedge clock);

    // Round-robin ties from reset
    pulse_reset();
    @(negedge clock);
    ord.delete();
    fork
      rand_port(1'b0, 4, 1'b0);
      rand_port(1'b1, 4, 1'b0);
    join
    @(negedge clock);
    chk("t4_ack_count", ord.size(), 8);
    foreach (ord[i]) chk("t4_rr_order", ord[i], i % 2);

    // Fixed priority starves B
    @(negedge clock);
    reset = 1'b1;
    a_we = 1'b0; b_we = 1'b0;
    a_addr = 19'h00010; b_addr = 19'h40010;
    a_req = 1'b1; b_req = 1'b1;
    s0 = n_ack_a2;
    l0 = n_ack_b2;
    reset2 = 1'b0;
    repeat (30) @(negedge clock);
    exp_a2 = 1 + (30 - (AC + 2)) / (AC + 3);
    chk("t4_pa_a_acks", n_ack_a2 - s0, exp_a2);
    chk("t4_pa_b_acks", n_ack_b2 - l0, 0);
    chk("t4_pa_b_rdata", b_rdata2, 0);
    a_req = 1'b0; b_req = 1'b0;
    reset2 = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Reset during a B write
    b_we = 1'b1; b_addr = 19'h40005; b_wdata = 8'h77;
    b_req = 1'b1;
    k = 0;
    while (!mem_store && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("t5_store_seen", mem_store, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_store_async", mem_store, 0);
    chk("t5_busy_async", busy, 0);
    b_req = 1'b0;
    s0 = n_ack_b;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("t5_no_b_ack", n_ack_b, s0);
    do_req(1'b1, 1'b1, 19'h40005, 8'h77, lat, idle);
    chk("t5_reissue_lat", lat, AC + 2);
    do_req(1'b1, 1'b0, 19'h40005, 8'h00, lat, idle);
    chk("t5_readback", b_rdata, 8'h77);

    @(negedge clock);
    chk("strobe_overlap", overlap, 0);
    chk("addr_stable", unstable, 0);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
